// File: rtl/score_keeper.sv
// Game-status sequencer: saturating 0-99 score, lives, pellet count and the overlay text flags.
// Optional macro SCORE_GHOST_BONUS_EN: ghost_caught adds 10 points; when undefined, ghost_caught is ignored.
module score_keeper #(
  parameter int NUM_PELLETS  = 240,
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 120,
  parameter int POWER_POINTS = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       pellet_eaten,
  input  logic       power_eaten,
  input  logic       ghost_caught,
  input  logic       pacman_dead,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [8:0] pellets_left,
  output logic       show_title,
  output logic       show_score,
  output logic       show_game_over,
  output logic       freeze,
  output logic       level_clear
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_DYING     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam int         CNT_W         = $clog2(DEATH_FRAMES + 1);
  localparam logic [8:0] PELLET_RELOAD = 9'(NUM_PELLETS);
  localparam logic [1:0] LIVES_LOAD    = 2'(START_LIVES);
  localparam logic [7:0] SCORE_MAX     = 8'd99;
  localparam logic [7:0] POWER_INC     = 8'(POWER_POINTS);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(DEATH_FRAMES - 1);

  // Sum cannot wrap: score is at most 99 and the increment at most 16.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] sum;
    sum = a + b;
    if (sum > SCORE_MAX) begin
      sat_add = SCORE_MAX;
    end else begin
      sat_add = sum;
    end
  endfunction

  state_t           state_r, state_next_s;
  logic [7:0]       score_r;
  logic [1:0]       lives_r;
  logic [8:0]       pellets_left_r;
  logic             level_clear_r;
  logic             show_title_r, show_score_r, show_game_over_r, freeze_r;
  logic             show_title_s, show_score_s, show_game_over_s, freeze_s;
  logic [CNT_W-1:0] frame_cnt_r;
  logic             frame_prev_r;
  logic             tick_s;
  logic             death_done_s;
  logic [7:0]       inc_s;
  logic [1:0]       dec_s;
  logic             clear_s;
  logic [8:0]       pellets_next_s;

  assign tick_s       = frame_clk & ~frame_prev_r;
  assign death_done_s = (state_r == ST_DYING) && tick_s && (frame_cnt_r == LAST_FRAME);

`ifdef SCORE_GHOST_BONUS_EN
  // Score increment with the ghost bonus term.
  always_comb begin
    inc_s = 8'd0;
    if (pellet_eaten) inc_s = inc_s + 8'd1; else inc_s = inc_s;
    if (power_eaten)  inc_s = inc_s + POWER_INC; else inc_s = inc_s;
    if (ghost_caught) inc_s = inc_s + 8'd10; else inc_s = inc_s;
  end
`else
  logic ghost_unused_s;
  assign ghost_unused_s = ghost_caught;

  // Score increment from pellets and power pellets only.
  always_comb begin
    inc_s = 8'd0;
    if (pellet_eaten) inc_s = inc_s + 8'd1; else inc_s = inc_s;
    if (power_eaten)  inc_s = inc_s + POWER_INC; else inc_s = inc_s;
  end
`endif

  // Pellet countdown; reaching zero (or going below it) reloads the maze.
  always_comb begin
    dec_s   = {1'b0, pellet_eaten} + {1'b0, power_eaten};
    clear_s = (dec_s != 2'd0) && ({7'd0, dec_s} >= pellets_left_r);
    if (clear_s) begin
      pellets_next_s = PELLET_RELOAD;
    end else begin
      pellets_next_s = pellets_left_r - {7'd0, dec_s};
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) state_next_s = ST_PLAYING;
        else       state_next_s = state_r;
      end
      ST_PLAYING: begin
        if (pacman_dead) state_next_s = ST_DYING;
        else             state_next_s = ST_PLAYING;
      end
      ST_DYING: begin
        if (death_done_s) state_next_s = (lives_r == 2'd0) ? ST_GAME_OVER : ST_PLAYING;
        else              state_next_s = ST_DYING;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Overlay flags decoded from the upcoming state, then registered.
  always_comb begin
    show_title_s     = 1'b0;
    show_score_s     = 1'b0;
    show_game_over_s = 1'b0;
    freeze_s         = 1'b1;
    case (state_next_s)
      ST_IDLE:      show_title_s = 1'b1;
      ST_PLAYING: begin
        show_score_s = 1'b1;
        freeze_s     = 1'b0;
      end
      ST_DYING:     show_score_s = 1'b1;
      ST_GAME_OVER: begin
        show_score_s     = 1'b1;
        show_game_over_s = 1'b1;
      end
      default:      show_title_s = 1'b1;
    endcase
  end

  // Score, lives, pellets, frame counter and registered flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      score_r          <= 8'd0;
      lives_r          <= 2'd0;
      pellets_left_r   <= PELLET_RELOAD;
      level_clear_r    <= 1'b0;
      show_title_r     <= 1'b1;
      show_score_r     <= 1'b0;
      show_game_over_r <= 1'b0;
      freeze_r         <= 1'b1;
      frame_cnt_r      <= '0;
      frame_prev_r     <= 1'b0;
    end else begin
      level_clear_r    <= 1'b0;
      show_title_r     <= show_title_s;
      show_score_r     <= show_score_s;
      show_game_over_r <= show_game_over_s;
      freeze_r         <= freeze_s;
      frame_prev_r     <= frame_clk;
      case (state_r)
        ST_IDLE, ST_GAME_OVER: begin
          if (start) begin
            score_r        <= 8'd0;
            lives_r        <= LIVES_LOAD;
            pellets_left_r <= PELLET_RELOAD;
          end
        end
        ST_PLAYING: begin
          score_r        <= sat_add(score_r, inc_s);
          pellets_left_r <= pellets_next_s;
          level_clear_r  <= clear_s;
          if (pacman_dead) begin
            lives_r     <= (lives_r != 2'd0) ? (lives_r - 2'd1) : 2'd0;
            frame_cnt_r <= '0;
          end
        end
        ST_DYING: begin
          if (tick_s) frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: frame_cnt_r <= '0;
      endcase
    end
  end

  assign score          = score_r;
  assign lives          = lives_r;
  assign pellets_left   = pellets_left_r;
  assign level_clear    = level_clear_r;
  assign show_title     = show_title_r;
  assign show_score     = show_score_r;
  assign show_game_over = show_game_over_r;
  assign freeze         = freeze_r;

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-status sequencer sitting directly upstream of the on-screen text overlay. It turns pellet, power-pellet, ghost and death events from the game logic into a saturating 0–99 `score` and a life count. It runs the title / playing / dying / game-over state machine, and its flags tell the overlay which text group to draw: the SCORE line, the PAC MAN title or GAME OVER.

## Interface
Parameters:
- `NUM_PELLETS`, 240: pellets per maze; drives `pellets_left` reload.
- `START_LIVES`, 3: lives loaded on game start (1–3).
- `DEATH_FRAMES`, 120: frame ticks spent in DYING.
- `POWER_POINTS`, 5: score added per power pellet.

Ports (one clock; reset is synchronous and active-high):
- `Clk`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high.
- `frame_clk`, in, 1: vsync-rate strobe, synchronous to `Clk`. Rising edge = one frame tick.
- `start`, in, 1: start-button pulse.
- `pellet_eaten`, in, 1: one-cycle pulse, +1 point.
- `power_eaten`, in, 1: one-cycle pulse, +`POWER_POINTS`.
- `ghost_caught`, in, 1: one-cycle pulse; +10 points when `SCORE_GHOST_BONUS_EN` is defined.
- `pacman_dead`, in, 1: one-cycle pulse.
- `score`, out, 8: 0–99, binary; consumer splits it into tens and units.
- `lives`, out, 2: remaining lives.
- `pellets_left`, out, 9: pellets remaining in the current maze.
- `show_title`, out, 1: high in IDLE.
- `show_score`, out, 1: high in PLAYING, DYING and GAME_OVER.
- `show_game_over`, out, 1: high in GAME_OVER.
- `freeze`, out, 1: movement halt. High in every state except PLAYING.
- `level_clear`, out, 1: one-cycle pulse when the last pellet is eaten.

## Operation
- States: IDLE, PLAYING, DYING, GAME_OVER.
- Reset values:
  - State: IDLE.
  - `score` = 0, `lives` = 0, `pellets_left` = `NUM_PELLETS`, `level_clear` = 0.
  - `show_title` = 1, `freeze` = 1, all other flags 0.
  - Frame-tick counter = 0; `frame_clk` history register = 0.
- IDLE: `start` moves to PLAYING and loads `score` = 0, `lives` = `START_LIVES`, `pellets_left` = `NUM_PELLETS`.
- GAME_OVER: `start` behaves exactly as in IDLE (goes straight to PLAYING with the same loads).
- PLAYING, event scoring:
  - Increment = `pellet_eaten`·1 + `power_eaten`·`POWER_POINTS` + `ghost_caught`·10 (ghost term only when the macro is defined).
  - Computed in 8 bits as `score` + increment; if the result exceeds 99, `score` becomes 99.
  - Events arriving together in one cycle are summed, not dropped.
- PLAYING, pellet count: each `pellet_eaten` or `power_eaten` decrements `pellets_left` by one per asserted input (both asserted = −2, floored at 0).
- PLAYING, level clear: when `pellets_left` would reach 0, `level_clear` pulses and `pellets_left` reloads to `NUM_PELLETS`. State stays PLAYING.
- PLAYING, death: `pacman_dead` moves to DYING, decrements `lives` and clears the frame counter.
  - Any event pulses in that same cycle are still scored and counted.
  - A `level_clear` in that same cycle still pulses and reloads.
- DYING: count frame ticks.
  - At `DEATH_FRAMES` ticks: go to GAME_OVER if `lives` == 0, else back to PLAYING.
  - All event inputs are ignored.
- Outside PLAYING: event inputs are ignored. `start` is ignored in PLAYING and DYING.
- Frame tick detection: a frame tick is `frame_clk` high AND its previous-cycle copy low.

## Timing
- All outputs are registered.
- An event pulse in cycle N is visible on `score` / `pellets_left` in cycle N+1.
- `level_clear` is high for exactly cycle N+1.
- State flags change in the cycle after the triggering `start`, `pacman_dead` or final frame tick.
- DYING lasts exactly `DEATH_FRAMES` frame-tick rising edges. The entry cycle is not a tick even if `frame_clk` rises in it.
- `Reset` asserted mid-game returns every output to its reset value in the next cycle, in any state. Reset has priority over all inputs.

## Configuration
- `SCORE_GHOST_BONUS_EN` defined: `ghost_caught` adds 10 points (subject to the 99 saturation).
- `SCORE_GHOST_BONUS_EN` not defined: `ghost_caught` is ignored entirely and the increment adder has only the pellet and power terms.

## Test plan
- Reset, then pulse `start` → next cycle `show_title` = 0, `show_score` = 1, `freeze` = 0, `lives` = 3, `score` = 0, `pellets_left` = 240.
- Score at 97, `pellet_eaten` + `power_eaten` in the same cycle → `score` = 99 (saturated), `pellets_left` drops by 2.
- `pellets_left` = 1, `pellet_eaten` → `level_clear` high for one cycle, `pellets_left` = 240, state stays PLAYING.
- Death with `lives` = 1 → `lives` = 0 and `freeze` = 1.
  - After 120 `frame_clk` rising edges → `show_game_over` = 1.
  - `pellet_eaten` during DYING leaves `score` unchanged.
- `ghost_caught` at `score` = 40 → `score` = 50 with the macro defined, 40 without it.
- `Reset` asserted in DYING with `score` = 63 → next cycle IDLE, `score` = 0, `lives` = 0, `show_title` = 1.
